// File: rtl/spi_rom_responder.sv
// SPI-flash responder answering READ (0x03) and JEDEC-ID (0x9F) from a byte-wide
// synchronous memory; all SPI pins are oversampled in the single clk domain.
module spi_rom_responder #(
  parameter int          ADDR_W   = 24,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              csn,
  input  logic              scl,
  input  logic              mosi,
  output logic              miso,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic              active
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_ID,
    S_IGNORE
  } state_e;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_JEDEC = 8'h9F;

  // Synchronizers and edge-detect history.
  logic [1:0] csn_s_q;
  logic [1:0] scl_s_q;
  logic [1:0] mosi_s_q;
  logic       csn_prev_q;
  logic       scl_prev_q;

  logic csn_sync;
  logic csn_fall;
  logic scl_rise;
  logic scl_fall;
  logic mosi_sync;

  // Protocol state.
  state_e            state_q;
  logic [4:0]        bit_cnt_q;
  logic [23:0]       sh_q;
  logic [7:0]        tx_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_rd_q;
  logic              miso_q;

  // Read-data holding register.
  logic       rd_pend_q;
  logic [7:0] hold_q;

  logic [23:0]       sh_in_d;
  logic [ADDR_W-1:0] addr_rx_d;

  // NOTE: csn history resets low so a csn already held low across reset
  // produces no falling edge; only a fresh high-to-low transition starts a frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      csn_s_q    <= 2'b00;
      scl_s_q    <= 2'b00;
      mosi_s_q   <= 2'b00;
      csn_prev_q <= 1'b0;
      scl_prev_q <= 1'b0;
    end else begin
      csn_s_q    <= {csn_s_q[0], csn};
      scl_s_q    <= {scl_s_q[0], scl};
      mosi_s_q   <= {mosi_s_q[0], mosi};
      csn_prev_q <= csn_s_q[1];
      scl_prev_q <= scl_s_q[1];
    end
  end

  assign csn_sync  = csn_s_q[1];
  assign csn_fall  = csn_prev_q & ~csn_sync;
  assign scl_rise  = scl_s_q[1] & ~scl_prev_q;
  assign scl_fall  = ~scl_s_q[1] & scl_prev_q;
  assign mosi_sync = mosi_s_q[1];

  assign sh_in_d   = {sh_q[22:0], mosi_sync};
  assign addr_rx_d = sh_in_d[ADDR_W-1:0];

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // mixing in blocking writes would make the result depend on statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      sh_q       <= '0;
      tx_q       <= '0;
      ptr_q      <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      mem_rd_q <= 1'b0;
      if (csn_sync) begin
        // Deselect wins over any coincident scl edge.
        state_q   <= S_IDLE;
        bit_cnt_q <= '0;
        miso_q    <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (csn_fall) begin
              state_q   <= S_CMD;
              bit_cnt_q <= '0;
            end
          end

          S_CMD: begin
            if (scl_rise) begin
              sh_q <= sh_in_d;
              if (bit_cnt_q == 5'd7) begin
                bit_cnt_q <= '0;
                if (sh_in_d[7:0] == CMD_READ) begin
                  state_q <= S_ADDR;
                end else if (sh_in_d[7:0] == CMD_JEDEC) begin
                  state_q <= S_ID;
                  sh_q    <= JEDEC_ID;
                end else begin
                  state_q <= S_IGNORE;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end

          S_ADDR: begin
            if (scl_rise) begin
              sh_q <= sh_in_d;
              if (bit_cnt_q == 5'd23) begin
                bit_cnt_q  <= '0;
                mem_addr_q <= addr_rx_d;
                mem_rd_q   <= 1'b1;
                ptr_q      <= addr_rx_d + ADDR_W'(1);
                state_q    <= S_DATA;
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end

          S_DATA: begin
            // bit_cnt_q counts rises within the current byte; a fall at 0 starts a byte.
            if (scl_fall) begin
              if (bit_cnt_q == 5'd0) begin
                miso_q <= hold_q[7];
                tx_q   <= {hold_q[6:0], 1'b0};
              end else begin
                miso_q <= tx_q[7];
                tx_q   <= {tx_q[6:0], 1'b0};
              end
            end else if (scl_rise) begin
              if (bit_cnt_q == 5'd7) begin
                bit_cnt_q  <= '0;
                mem_addr_q <= ptr_q;
                mem_rd_q   <= 1'b1;
                ptr_q      <= ptr_q + ADDR_W'(1);
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end

          S_ID: begin
            // Zeros shift in behind the ID, so miso holds 0 once it is exhausted.
            if (scl_fall) begin
              miso_q <= sh_q[23];
              sh_q   <= {sh_q[22:0], 1'b0};
            end
          end

          S_IGNORE: begin
            miso_q <= 1'b0;
          end

          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_pend_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      rd_pend_q <= mem_rd_q;
      if (rd_pend_q) begin
        hold_q <= mem_data;
      end
    end
  end

  assign miso     = miso_q;
  assign mem_addr = mem_addr_q;
  assign mem_rd   = mem_rd_q;
  assign active   = (state_q != S_IDLE);

endmodule

// File: doc/spi_rom_responder.md
# spi_rom_responder

SPI-flash responder that answers a serial master's READ (0x03) and JEDEC-ID (0x9F) commands from a byte-wide synchronous memory. It is the slave end of the `scl`/`mosi`/`miso` link that our SPI ROM reader drives. It sits in FPGA builds and benches in place of a physical flash, backed by a block RAM preloaded with the program image. All SPI inputs are oversampled in the `clk` domain; there is no second clock.

## Interface
- `ADDR_W`, 24: memory address width. Command address bits above `ADDR_W` are ignored.
- `JEDEC_ID`, 24'hEF4016: three bytes returned by 0x9F, MSB first.
- `clk`  in  1  system clock; sole clock of the block.
- `rstn`  in  1  reset, asynchronous, active-low.
- `csn`  in  1  chip select from master, active-low; asynchronous to `clk`.
- `scl`  in  1  serial clock from master, mode 0 (idle low); asynchronous to `clk`.
- `mosi`  in  1  serial data from master.
- `miso`  out  1  serial data to master.
- `mem_addr`  out  ADDR_W  memory read address.
- `mem_rd`  out  1  one-cycle read strobe.
- `mem_data`  in  8  memory read data, valid exactly 1 `clk` after `mem_rd`.
- `active`  out  1  high while a transaction is selected (state ≠ IDLE).

## Operation
- `csn`, `scl` and `mosi` each pass through a 2-FF synchronizer. `scl` edge detect runs on the synchronized value.
- `mosi` is sampled on a detected `scl` rise. `miso` changes on a detected `scl` fall. Bits are MSB first.
- States and transitions:
  - IDLE: enter CMD when synchronized `csn` falls.
  - CMD: shift 8 bits. 0x03 goes to ADDR. 0x9F goes to ID and loads the ID shifter with `JEDEC_ID`. Any other value goes to IGNORE.
  - ADDR: shift 24 bits. On the rise that samples the 24th bit, assert `mem_rd` with `mem_addr` = received address [ADDR_W-1:0]. The internal pointer becomes address+1. Then go to DATA.
  - DATA: the byte captured from `mem_data` loads the output shifter on the next `scl` fall and drives bit 7. Each later fall shifts one bit out. On the rise that samples bit 0 of the current byte, issue `mem_rd` at the pointer and increment it. Streaming is unlimited. The pointer wraps from 2^ADDR_W-1 to 0.
  - ID: shift out 24 ID bits, then hold `miso`=0 (no repetition).
  - IGNORE: `miso`=0, no memory access.
- Synchronized `csn` high in any state returns to IDLE on the next `clk`, clears the bit counters and drives `miso` to 0. If `csn` rises and an `scl` edge is detected in the same cycle, `csn` wins and the edge is discarded.
- During CMD and ADDR, `miso`=0.
- `mem_data` is captured into a holding register one cycle after `mem_rd` and kept until used.

## Timing
- Reset values: `miso`=0, `mem_rd`=0, `mem_addr`=0, `active`=0, state IDLE, all shifters and counters 0.
- Pin-to-internal latency: 2 sync cycles plus 1 edge-detect cycle. An `scl` edge therefore acts on the 3rd `clk` after it.
- Required `scl` phase: `scl` high and `scl` low each last ≥4 `clk` periods, which caps `scl` at `clk`/8. `csn` setup and hold to the first/last `scl` edge is ≥4 `clk` periods.
- Memory read: 1 `clk` after `mem_rd`, data is latched. It is always ready before the following `scl` fall given the rule above.
- `miso` updates 3 `clk` after each `scl` fall, and ≥1 `clk` before the next rise reaches the master.
- `mem_rd` is a single-cycle pulse, once per byte. It is never asserted outside ADDR→DATA or DATA.
- `rstn` asserted mid-transaction: all outputs take reset values immediately. After release, the block waits in IDLE for a fresh `csn` fall; a `csn` already low is ignored until it goes high then low.

## Test plan
- READ at 0x000000, memory = i & 0xFF, 4 bytes clocked at `clk`/8 → `miso` bytes 0x00,0x01,0x02,0x03; `mem_rd` pulses 5 times (one prefetch) with `mem_addr` 0..4.
- 0x9F then 32 clocks → bytes 0xEF,0x40,0x16,0x00; no `mem_rd`.
- READ at 0xFFFFFE with `ADDR_W`=24 → `mem_addr` 0xFFFFFE, 0xFFFFFF, 0x000000; data follows the wrap.
- Unknown command 0xAB then 16 clocks → `miso` stays 0, no `mem_rd`; a following `csn` cycle with 0x03 at 0x000010 returns memory[0x10].
- `csn` raised after 12 address bits, then a new READ at 0x000020 → `active` drops within 3 `clk`; the new read returns memory[0x20] with no residue from the aborted frame.
- `rstn` pulsed low mid-DATA → `miso`, `mem_rd`, `active` go 0 at once; no output until `csn` toggles high then low again.
